arbiter_mux: RTL
================

Name: arbiter_mux

Overview:
- Registered, N-channel, valid/ready arbitrating multiplexer; the successor to the plain combinational select-mux.
- The sel input is replaced by an internal arbiter (round-robin or fixed priority) with multi-beat packet locking.
- It drives a one-entry output pipeline register.
- Used on the rvsimple bus side to merge instruction-fetch, data and debug requesters onto a single memory port.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 2, number of input channels (>=2).
- SEL_BITS, $clog2(CHANNELS), width of the channel index.
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins).

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH x CHANNELS  per-channel data.
- in_valid  input  CHANNELS  per-channel beat valid.
- in_last  input  CHANNELS  per-channel end-of-packet marker, qualified by in_valid.
- in_ready  output  CHANNELS  per-channel accept; combinational, at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered beat valid.
- out_last  output  1  registered end-of-packet marker.
- out_sel  output  SEL_BITS  registered index of the channel that sourced the current output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset), sampled only at the clock edge.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Lock state = UNLOCKED; round-robin pointer = 0; in_ready = all 0 while reset is high.
- Output register:
  - can_load = !out_valid || out_ready.
  - A beat is accepted from channel g when can_load && in_valid[g] && grant==g. On the next edge: out_data=in_data[g], out_last=in_last[g], out_sel=g, out_valid=1.
  - If out_valid && out_ready and no beat is accepted, out_valid goes to 0 and the other output fields hold.
  - Latency is 1 cycle input-to-output. Full throughput is one beat per cycle with out_ready held high.
  - While out_valid && !out_ready, all outputs hold stable.
- in_ready[i] = can_load && grant==i && in_valid[i]. It has a combinational path from out_ready, which is accepted by design.
- Lock state machine:
  - UNLOCKED: grant is computed from in_valid.
    - Accepted beat with in_last=0 -> LOCKED(g).
    - Accepted beat with in_last=1 -> remain UNLOCKED. This is a single-beat packet.
  - LOCKED(g): grant is fixed to g regardless of other valids.
    - Accepted beat with in_last=1 -> UNLOCKED.
    - g deasserting in_valid mid-packet does not release the lock; no other channel is served.
- Grant computation:
  - ROUND_ROBIN=1: search from pointer upward, wrapping at CHANNELS-1 -> 0; the first valid index wins.
  - ROUND_ROBIN=0: the lowest valid index wins; the pointer is ignored.
  - No valid request: no grant, all in_ready=0.
- Pointer update: only on acceptance of a beat with in_last=1 from channel g. The pointer becomes g+1, wrapping to 0 when g=CHANNELS-1. It is unchanged at other times.
- Simultaneous events:
  - Output drain and new load in the same cycle yield the new beat with no bubble.
  - A request arriving while another channel holds the lock waits.
- Reset mid-packet:
  - Lock is dropped, pointer returns to 0, and the pending output beat is discarded (out_valid=0).
  - No beat is accepted in the reset cycle.
- CHANNELS not a power of two: index arithmetic wraps at CHANNELS, never at 2^SEL_BITS. out_sel never exceeds CHANNELS-1.

Test Plan:
- Reset: hold reset high 2 cycles while all in_valid=1 -> out_valid=0, out_sel=0, in_ready=0 throughout. After deassert, channel 0 is granted first.
- Round-robin fairness: CHANNELS=4, ROUND_ROBIN=1, all channels stream single-beat packets (in_last=1), out_ready=1 -> out_sel sequence 0,1,2,3,0,1. One beat per cycle, first out_valid 1 cycle after the first accept.
- Packet lock: ch1 sends a 3-beat packet (data 0xA1,0xA2,0xA3; last on the 3rd) while ch0 is continuously valid -> three consecutive beats from ch1 with out_last only on 0xA3. Ch0 is granted on the next cycle, and mid-packet gaps on ch1 do not release the lock.
- Backpressure: out_valid=1 with data 0x55, out_ready=0 for 5 cycles -> out_data stays 0x55, all in_ready=0. On out_ready=1 with ch2 valid (data 0x66), 0x66 appears the next cycle with no bubble.
- Fixed priority and wrap: ROUND_ROBIN=0, CHANNELS=3, ch0 and ch2 always valid -> out_sel is always 0. With ROUND_ROBIN=1 and CHANNELS=3 (non-power-of-two) -> out_sel alternates 0,2,0,2, and the pointer wraps past index 2 to 0.
- Reset mid-packet: ch3 locked after 1 of 4 beats, reset pulsed 1 cycle -> out_valid=0 the next cycle. With ch1 and ch3 valid afterwards, ch1 is granted (pointer back at 0).

Source files
------------

// File: rtl/arbiter_mux.sv
// N-channel valid/ready arbitrating multiplexer with packet locking and a one-entry
// output register; merges several requesters onto a single downstream port.
//
// state    | meaning
// UNLOCKED | grant computed each cycle from in_valid (round-robin or fixed priority)
// LOCKED   | grant pinned to r_lock_ch until that channel delivers its last beat
module arbiter_mux #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 2,
    parameter int SEL_BITS    = $clog2(CHANNELS),
    parameter int ROUND_ROBIN = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [CHANNELS-1:0][WIDTH-1:0]     in_data,
    input  logic [CHANNELS-1:0]                in_valid,
    input  logic [CHANNELS-1:0]                in_last,
    output logic [CHANNELS-1:0]                in_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_valid,
    output logic                               out_last,
    output logic [SEL_BITS-1:0]                out_sel,
    input  logic                               out_ready
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t         r_state;
    lock_state_t         w_state_next;
    logic [SEL_BITS-1:0] r_lock_ch;
    logic [SEL_BITS-1:0] r_ptr;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic                r_out_last;
    logic [SEL_BITS-1:0] r_out_sel;

    logic [SEL_BITS-1:0] w_grant;
    logic                w_grant_valid;
    logic                w_can_load;
    logic                w_accept;
    logic                w_last;

    // Search wraps at CHANNELS, not 2^SEL_BITS, so non-power-of-two counts stay in range.
    always_comb begin
        int idx;
        w_grant       = '0;
        w_grant_valid = 1'b0;
        idx           = 0;
        if (r_state == LOCKED) begin
            w_grant       = r_lock_ch;
            w_grant_valid = 1'b1;
        end else begin
            for (int off = 0; off < CHANNELS; off++) begin
                if (ROUND_ROBIN != 0) begin
                    idx = int'(r_ptr) + off;
                    if (idx >= CHANNELS) idx = idx - CHANNELS;
                end else begin
                    idx = off;
                end
                if (!w_grant_valid && in_valid[idx]) begin
                    w_grant       = SEL_BITS'(idx);
                    w_grant_valid = 1'b1;
                end
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_accept   = !reset && w_can_load && w_grant_valid && in_valid[w_grant];
    assign w_last     = in_last[w_grant];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_accept && (w_grant == SEL_BITS'(i))) in_ready[i] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_last ? UNLOCKED : LOCKED;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= UNLOCKED;
            r_lock_ch   <= '0;
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_lock_ch   <= w_grant;
                r_out_data  <= in_data[w_grant];
                r_out_last  <= w_last;
                r_out_sel   <= w_grant;
                r_out_valid <= 1'b1;
                if (w_last) begin
                    r_ptr <= (w_grant == SEL_BITS'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule
